spi_ram_master: RTL

- Host-side SPI initiator that drives the SPI slave + RAM block from the far end of the serial link.
- Accepts single-word write or read commands over a valid/ready handshake.
- Encodes each command as two 10-bit RAM command frames: 00/01 codes for writes, 10/11 codes for reads.
- Generates SCLK/SS_n/MOSI, captures the 8-bit read byte on MISO and returns it on a one-cycle response strobe.

---
 rtl/spi_ram_master.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_ram_master
//  Purpose  : Host-side SPI initiator for the SPI slave + RAM block. Turns a
//             single write/read command into two 11-bit frames, where the
//             frame MSB is the rw flag and the low 10 bits are the RAM command
//             word. A write sends {0,00,addr} then {0,01,wdata}. A read sends
//             {1,10,addr} then {1,11,00}, waits RD_WAIT SCLK periods and
//             clocks in 8 MISO bits. SPI mode 0, MSB first.
//  Ports    : clk, rst (async, active high)
//             cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata : command handshake
//             rsp_valid/rsp_rdata : one-cycle completion strobe + read byte
//             busy                : high from acceptance until back in IDLE
//             sclk/ss_n/mosi/miso : SPI pins
//  Revision : 1.0 - initial release
// ============================================================================
module spi_ram_master #(
  parameter int CLK_DIV = 4,  // clk cycles per SCLK period (even, >= 2)
  parameter int RD_WAIT = 1   // idle SCLK periods before read data
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV + 1);
  localparam int PW   = 16;

  localparam logic [CW-1:0] c_half_last = CW'(HALF - 1);
  localparam logic [CW-1:0] c_gap_last  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [PW-1:0] c_per_one   = PW'(1);
  localparam logic [PW-1:0] c_cmd_last  = PW'(10);
  localparam logic [PW-1:0] c_wait_last = PW'(RD_WAIT - 1);
  localparam logic [PW-1:0] c_rx_last   = PW'(7);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FRAME_A = 3'd1,
    S_GAP_A   = 3'd2,
    S_FRAME_B = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RX8     = 3'd5,
    S_GAP_END = 3'd6
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_hcnt, w_hcnt_nx;     // half-period counter / gap counter
  logic [PW-1:0]   r_pcnt, w_pcnt_nx;     // SCLK periods finished in this phase
  logic [10:0]     r_tx, w_tx_nx;         // outgoing frame, bit 10 is on mosi
  logic [7:0]      r_rx, w_rx_nx;         // incoming read byte
  logic            r_rw, w_rw_nx;
  logic [7:0]      r_wdata, w_wdata_nx;
  logic            w_sclk_nx, w_ss_n_nx, w_mosi_nx, w_rsp_valid_nx;
  logic [7:0]      w_rdata_nx;
  logic            w_half_end;

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign w_half_end = (r_hcnt == c_half_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hcnt    <= '0;
      r_pcnt    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rw      <= 1'b0;
      r_wdata   <= '0;
      sclk      <= 1'b0;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_hcnt    <= w_hcnt_nx;
      r_pcnt    <= w_pcnt_nx;
      r_tx      <= w_tx_nx;
      r_rx      <= w_rx_nx;
      r_rw      <= w_rw_nx;
      r_wdata   <= w_wdata_nx;
      sclk      <= w_sclk_nx;
      ss_n      <= w_ss_n_nx;
      mosi      <= w_mosi_nx;
      rsp_valid <= w_rsp_valid_nx;
      rsp_rdata <= w_rdata_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_hcnt_nx      = r_hcnt;
    w_pcnt_nx      = r_pcnt;
    w_tx_nx        = r_tx;
    w_rx_nx        = r_rx;
    w_rw_nx        = r_rw;
    w_wdata_nx     = r_wdata;
    w_sclk_nx      = sclk;
    w_ss_n_nx      = ss_n;
    w_mosi_nx      = mosi;
    w_rsp_valid_nx = 1'b0;
    w_rdata_nx     = rsp_rdata;

    case (r_state)
      S_IDLE: begin
        // cmd_ready is high in IDLE, so cmd_valid alone is the handshake
        if (cmd_valid) begin
          w_rw_nx    = cmd_rw;
          w_wdata_nx = cmd_wdata;
          // Frame A: write {0,00,addr}, read {1,10,addr}
          w_tx_nx    = {cmd_rw, cmd_rw, 1'b0, cmd_addr};
          w_mosi_nx  = cmd_rw;
          w_ss_n_nx  = 1'b0;
          w_hcnt_nx  = '0;
          w_pcnt_nx  = '0;
          w_state_nx = S_FRAME_A;
        end
      end

      S_FRAME_A, S_FRAME_B, S_RD_WAIT, S_RX8: begin
        if (!w_half_end) begin
          w_hcnt_nx = r_hcnt + c_cnt_one;
        end else begin
          w_hcnt_nx = '0;
          if (!sclk) begin
            // rising edge: the only place MISO is sampled
            w_sclk_nx = 1'b1;
            if (r_state == S_RX8) begin
              w_rx_nx = {r_rx[6:0], miso};
            end
          end else begin
            // falling edge: ends one SCLK period, advances MOSI
            w_sclk_nx = 1'b0;
            w_pcnt_nx = r_pcnt + c_per_one;
            w_tx_nx   = {r_tx[9:0], 1'b0};
            w_mosi_nx = r_tx[9];
            case (r_state)
              S_FRAME_A: begin
                if (r_pcnt == c_cmd_last) begin
                  w_ss_n_nx  = 1'b1;
                  w_mosi_nx  = 1'b0;
                  w_state_nx = S_GAP_A;
                end
              end
              S_FRAME_B: begin
                if (r_pcnt == c_cmd_last) begin
                  w_pcnt_nx = '0;
                  if (!r_rw) begin
                    w_ss_n_nx      = 1'b1;
                    w_mosi_nx      = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_state_nx     = S_GAP_END;
                  end else if (RD_WAIT > 0) begin
                    w_state_nx = S_RD_WAIT;
                  end else begin
                    w_state_nx = S_RX8;
                  end
                end
              end
              S_RD_WAIT: begin
                if (r_pcnt == c_wait_last) begin
                  w_pcnt_nx  = '0;
                  w_state_nx = S_RX8;
                end
              end
              S_RX8: begin
                if (r_pcnt == c_rx_last) begin
                  w_ss_n_nx      = 1'b1;
                  w_mosi_nx      = 1'b0;
                  w_rsp_valid_nx = 1'b1;
                  w_rdata_nx     = r_rx;
                  w_state_nx     = S_GAP_END;
                end
              end
              default: ;
            endcase
          end
        end
      end

      S_GAP_A: begin
        if (r_hcnt == c_gap_last) begin
          // Frame B: write {0,01,wdata}, read {1,11,00}
          w_tx_nx    = {r_rw, r_rw, 1'b1, (r_rw ? 8'h00 : r_wdata)};
          w_mosi_nx  = r_rw;
          w_ss_n_nx  = 1'b0;
          w_hcnt_nx  = '0;
          w_pcnt_nx  = '0;
          w_state_nx = S_FRAME_B;
        end else begin
          w_hcnt_nx = r_hcnt + c_cnt_one;
        end
      end

      S_GAP_END: begin
        if (r_hcnt == c_gap_last) begin
          w_hcnt_nx  = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_hcnt_nx = r_hcnt + c_cnt_one;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
